dqd_bp_seq: RTL and testbench

DQD_BP_SEQ -- requirements
Module: dqd_bp_seq

---
 rtl/dqd_bp_seq_if.sv | 49 ++++
 rtl/dqd_bp_seq.sv | 161 ++++++++++++++++
 tb/tb_dqd_bp_seq.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dqd_bp_seq_if.sv
// Bundle between the dqd_bp_seq sequencer and its environment: link loading,
// sweep control, datapath operand/result exchange and the dtau result handshake.
interface dqd_bp_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             load_en;
  logic [2:0]       load_link;
  logic [WIDTH-1:0] load_sinq, load_cosq;
  logic [WIDTH-1:0] load_f_AX, load_f_AY, load_f_AZ, load_f_LX, load_f_LY, load_f_LZ;

  logic             start;
  logic             busy;
  logic [2:0]       link_out;
  logic [WIDTH-1:0] sinq_out, cosq_out;
  logic [WIDTH-1:0] curr_out_AX, curr_out_AY, curr_out_AZ, curr_out_LX, curr_out_LY, curr_out_LZ;
  logic [WIDTH-1:0] prev_out_AX, prev_out_AY, prev_out_AZ, prev_out_LX, prev_out_LY, prev_out_LZ;
  logic [WIDTH-1:0] prev_upd_in_AX, prev_upd_in_AY, prev_upd_in_AZ;
  logic [WIDTH-1:0] prev_upd_in_LX, prev_upd_in_LY, prev_upd_in_LZ;
  logic [WIDTH-1:0] dtau_in;

  logic             dtau_valid, dtau_ready;
  logic [2:0]       dtau_link;
  logic [WIDTH-1:0] dtau_out;
  logic             done;

  modport master (
    output load_en, load_link, load_sinq, load_cosq,
           load_f_AX, load_f_AY, load_f_AZ, load_f_LX, load_f_LY, load_f_LZ,
           start, dtau_ready, dtau_in,
           prev_upd_in_AX, prev_upd_in_AY, prev_upd_in_AZ,
           prev_upd_in_LX, prev_upd_in_LY, prev_upd_in_LZ,
    input  busy, link_out, sinq_out, cosq_out,
           curr_out_AX, curr_out_AY, curr_out_AZ, curr_out_LX, curr_out_LY, curr_out_LZ,
           prev_out_AX, prev_out_AY, prev_out_AZ, prev_out_LX, prev_out_LY, prev_out_LZ,
           dtau_valid, dtau_link, dtau_out, done
  );

  modport slave (
    input  load_en, load_link, load_sinq, load_cosq,
           load_f_AX, load_f_AY, load_f_AZ, load_f_LX, load_f_LY, load_f_LZ,
           start, dtau_ready, dtau_in,
           prev_upd_in_AX, prev_upd_in_AY, prev_upd_in_AZ,
           prev_upd_in_LX, prev_upd_in_LY, prev_upd_in_LZ,
    output busy, link_out, sinq_out, cosq_out,
           curr_out_AX, curr_out_AY, curr_out_AZ, curr_out_LX, curr_out_LY, curr_out_LZ,
           prev_out_AX, prev_out_AY, prev_out_AZ, prev_out_LX, prev_out_LY, prev_out_LZ,
           dtau_valid, dtau_link, dtau_out, done
  );
endinterface

// File: rtl/dqd_bp_seq.sv
// Backward-pass sequencer for df/dqd: walks links 7..1, feeds link k and k-1 to an
// external datapath, writes the updated k-1 vector back and emits dtau per link.
module dqd_bp_seq #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DECIMAL_BITS = 16
) (
  input logic         clk,
  input logic         reset,
  dqd_bp_seq_if.slave bus
);
  typedef logic [WIDTH-1:0] word_t;
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, EMIT, DONE} state_t;

  // Values are fixed-point with DECIMAL_BITS fraction bits but are only moved, never scaled.
  if (DECIMAL_BITS > WIDTH) begin : g_fraction_exceeds_word
  end

  state_t     state;
  logic [2:0] k;
  word_t      sinq_m [1:7];
  word_t      cosq_m [1:7];
  word_t      acc    [1:7][0:5];

  word_t      load_f   [0:5];
  word_t      prev_upd [0:5];

  logic       busy_r, done_r, dtau_valid_r;
  logic [2:0] link_r, dtau_link_r;
  word_t      sinq_r, cosq_r, dtau_r;
  word_t      curr_r [0:5];
  word_t      prev_r [0:5];

  logic       issue_go;
  logic [2:0] issue_link;

  assign load_f   = '{bus.load_f_AX, bus.load_f_AY, bus.load_f_AZ,
                      bus.load_f_LX, bus.load_f_LY, bus.load_f_LZ};
  assign prev_upd = '{bus.prev_upd_in_AX, bus.prev_upd_in_AY, bus.prev_upd_in_AZ,
                      bus.prev_upd_in_LX, bus.prev_upd_in_LY, bus.prev_upd_in_LZ};

  // Operand registers are loaded on the edge entering ISSUE so they are stable for ISSUE and CAPTURE.
  always_comb begin
    issue_go   = 1'b0;
    issue_link = k;
    if (state == IDLE && bus.start) begin
      issue_go = 1'b1;
    end else if (state == EMIT && bus.dtau_ready && k != 3'd1) begin
      issue_go   = 1'b1;
      issue_link = k - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      k            <= 3'd7;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      dtau_valid_r <= 1'b0;
      link_r       <= '0;
      dtau_link_r  <= '0;
      sinq_r       <= '0;
      cosq_r       <= '0;
      dtau_r       <= '0;
      for (int unsigned i = 0; i < 6; i++) begin
        curr_r[i] <= '0;
        prev_r[i] <= '0;
      end
      for (int unsigned l = 1; l < 8; l++) begin
        sinq_m[l] <= '0;
        cosq_m[l] <= '0;
        for (int unsigned i = 0; i < 6; i++) acc[l][i] <= '0;
      end
    end else begin
      done_r <= 1'b0;

      if (bus.load_en && !busy_r && bus.load_link != 3'd0) begin
        sinq_m[bus.load_link] <= bus.load_sinq;
        cosq_m[bus.load_link] <= bus.load_cosq;
        for (int unsigned i = 0; i < 6; i++) acc[bus.load_link][i] <= load_f[i];
      end

      if (issue_go) begin
        link_r <= issue_link;
        sinq_r <= sinq_m[issue_link];
        cosq_r <= cosq_m[issue_link];
        for (int unsigned i = 0; i < 6; i++) begin
          curr_r[i] <= acc[issue_link][i];
          prev_r[i] <= (issue_link == 3'd1) ? '0 : acc[issue_link - 3'd1][i];
        end
      end

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= ISSUE;
            busy_r <= 1'b1;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          if (k != 3'd1) begin
            for (int unsigned i = 0; i < 6; i++) acc[k - 3'd1][i] <= prev_upd[i];
          end
          dtau_r       <= bus.dtau_in;
          dtau_valid_r <= 1'b1;
          dtau_link_r  <= k;
          link_r       <= '0;
          sinq_r       <= '0;
          cosq_r       <= '0;
          for (int unsigned i = 0; i < 6; i++) begin
            curr_r[i] <= '0;
            prev_r[i] <= '0;
          end
          state <= EMIT;
        end
        EMIT: begin
          if (bus.dtau_ready) begin
            dtau_valid_r <= 1'b0;
            dtau_link_r  <= '0;
            dtau_r       <= '0;
            if (k == 3'd1) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              k     <= k - 3'd1;
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          k      <= 3'd7;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.link_out    = link_r;
  assign bus.sinq_out    = sinq_r;
  assign bus.cosq_out    = cosq_r;
  assign bus.curr_out_AX = curr_r[0];
  assign bus.curr_out_AY = curr_r[1];
  assign bus.curr_out_AZ = curr_r[2];
  assign bus.curr_out_LX = curr_r[3];
  assign bus.curr_out_LY = curr_r[4];
  assign bus.curr_out_LZ = curr_r[5];
  assign bus.prev_out_AX = prev_r[0];
  assign bus.prev_out_AY = prev_r[1];
  assign bus.prev_out_AZ = prev_r[2];
  assign bus.prev_out_LX = prev_r[3];
  assign bus.prev_out_LY = prev_r[4];
  assign bus.prev_out_LZ = prev_r[5];
  assign bus.dtau_valid  = dtau_valid_r;
  assign bus.dtau_link   = dtau_link_r;
  assign bus.dtau_out    = dtau_r;
endmodule

// File: tb/tb_dqd_bp_seq.sv
// Scoreboard bench for dqd_bp_seq with a toy datapath: prev_upd = prev + curr, dtau = curr_AZ.
module tb_dqd_bp_seq;
  localparam int unsigned W = 32;
  typedef logic [W-1:0] word_t;
  typedef struct {
    logic [2:0] link;
    word_t      sinq;
    word_t      cosq;
    word_t      curr [6];
    word_t      prev [6];
  } iss_t;
  typedef struct {
    logic [2:0] link;
    word_t      dtau;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned errors = 0;
  int unsigned checks = 0;

  iss_t  iss_q[$];
  res_t  res_q[$];
  word_t m_acc [8][6];
  word_t m_sin [8];
  word_t m_cos [8];
  word_t curr_v [6];
  word_t prev_v [6];
  word_t held_curr [6];
  logic [2:0] last_link = '0;
  iss_t  mon_e;
  res_t  mon_r;

  dqd_bp_seq_if #(.WIDTH(W)) bus ();
  dqd_bp_seq #(.WIDTH(W), .DECIMAL_BITS(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  assign curr_v[0] = bus.curr_out_AX;
  assign curr_v[1] = bus.curr_out_AY;
  assign curr_v[2] = bus.curr_out_AZ;
  assign curr_v[3] = bus.curr_out_LX;
  assign curr_v[4] = bus.curr_out_LY;
  assign curr_v[5] = bus.curr_out_LZ;
  assign prev_v[0] = bus.prev_out_AX;
  assign prev_v[1] = bus.prev_out_AY;
  assign prev_v[2] = bus.prev_out_AZ;
  assign prev_v[3] = bus.prev_out_LX;
  assign prev_v[4] = bus.prev_out_LY;
  assign prev_v[5] = bus.prev_out_LZ;

  assign bus.prev_upd_in_AX = bus.prev_out_AX + bus.curr_out_AX;
  assign bus.prev_upd_in_AY = bus.prev_out_AY + bus.curr_out_AY;
  assign bus.prev_upd_in_AZ = bus.prev_out_AZ + bus.curr_out_AZ;
  assign bus.prev_upd_in_LX = bus.prev_out_LX + bus.curr_out_LX;
  assign bus.prev_upd_in_LY = bus.prev_out_LY + bus.curr_out_LY;
  assign bus.prev_upd_in_LZ = bus.prev_out_LZ + bus.curr_out_LZ;
  assign bus.dtau_in        = bus.curr_out_AZ;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < 8; l++) begin
      m_sin[l] = '0;
      m_cos[l] = '0;
      for (int i = 0; i < 6; i++) m_acc[l][i] = '0;
    end
  endtask

  task automatic model_sweep();
    iss_t e;
    res_t r;
    for (int k = 7; k >= 1; k--) begin
      e.link = k[2:0];
      e.sinq = m_sin[k];
      e.cosq = m_cos[k];
      for (int i = 0; i < 6; i++) begin
        e.curr[i] = m_acc[k][i];
        e.prev[i] = (k > 1) ? m_acc[k-1][i] : '0;
      end
      iss_q.push_back(e);
      r.link = k[2:0];
      r.dtau = m_acc[k][2];
      res_q.push_back(r);
      if (k > 1) for (int i = 0; i < 6; i++) m_acc[k-1][i] = m_acc[k-1][i] + m_acc[k][i];
    end
  endtask

  task automatic drive_load(input logic [2:0] l, input word_t s, input word_t c, input word_t f[6]);
    bus.load_link = l;
    bus.load_sinq = s;
    bus.load_cosq = c;
    bus.load_f_AX = f[0];
    bus.load_f_AY = f[1];
    bus.load_f_AZ = f[2];
    bus.load_f_LX = f[3];
    bus.load_f_LY = f[4];
    bus.load_f_LZ = f[5];
  endtask

  task automatic load_entry(input int unsigned l, input word_t s, input word_t c, input word_t f[6]);
    @(negedge clk);
    drive_load(l[2:0], s, c, f);
    bus.load_en = 1'b1;
    @(negedge clk);
    bus.load_en = 1'b0;
    m_sin[l] = s;
    m_cos[l] = c;
    for (int i = 0; i < 6; i++) m_acc[l][i] = f[i];
  endtask

  // Result and operand checks happen here; expectations come from model_sweep.
  always @(negedge clk) begin
    if (reset) begin
      last_link = '0;
    end else begin
      if (bus.dtau_valid && bus.dtau_ready) begin
        if (res_q.size() == 0) check("result_unexpected", bus.dtau_valid, 1'b0);
        else begin
          mon_r = res_q.pop_front();
          check("dtau_link", bus.dtau_link, mon_r.link);
          check("dtau_out", bus.dtau_out, mon_r.dtau);
        end
      end
      if (bus.link_out != 3'd0 && bus.link_out != last_link) begin
        if (iss_q.size() == 0) check("issue_unexpected", bus.link_out, 3'd0);
        else begin
          mon_e = iss_q.pop_front();
          check("link_out", bus.link_out, mon_e.link);
          check("sinq_out", bus.sinq_out, mon_e.sinq);
          check("cosq_out", bus.cosq_out, mon_e.cosq);
          for (int i = 0; i < 6; i++) begin
            check("curr_out", curr_v[i], mon_e.curr[i]);
            check("prev_out", prev_v[i], mon_e.prev[i]);
          end
        end
        held_curr = curr_v;
      end else if (bus.link_out != 3'd0) begin
        for (int i = 0; i < 6; i++) check("curr_hold", curr_v[i], held_curr[i]);
      end
      last_link = bus.link_out;
    end
  end

  task automatic do_sweep(input int unsigned stall_link, input bit poke);
    int unsigned n, hs, stall, done_cyc;
    logic [2:0]  h_link;
    word_t       h_dtau;
    model_sweep();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 1; hs = 0; stall = 0; done_cyc = 0; h_link = '0; h_dtau = '0;
    while (n <= 200 && done_cyc == 0) begin
      if (bus.dtau_valid) begin
        if (stall_link != 0 && bus.dtau_link == stall_link[2:0] && stall <= 5) begin
          if (stall == 0) begin
            h_link = bus.dtau_link;
            h_dtau = bus.dtau_out;
            bus.dtau_ready = 1'b0;
          end else begin
            check("stall_valid", bus.dtau_valid, 1'b1);
            check("stall_link", bus.dtau_link, h_link);
            check("stall_dtau", bus.dtau_out, h_dtau);
            check("stall_no_issue", bus.link_out, 3'd0);
            check("stall_busy", bus.busy, 1'b1);
          end
          if (stall == 5) bus.dtau_ready = 1'b1;
          stall++;
        end else if (stall_link == 0) begin
          hs++;
          check("valid_cycle", n, 3 * hs);
          if (hs == 1) check("first_link", bus.dtau_link, 3'd7);
        end
      end
      if (bus.done) done_cyc = n;
      if (poke && (n == 4 || n == 10)) begin
        bus.start   = 1'b1;
        bus.load_en = 1'b1;
      end else begin
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
      end
      if (done_cyc == 0) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
    bus.dtau_ready = 1'b1;
    check("done_cycle", done_cyc, (stall_link != 0) ? 27 : 22);
    if (stall_link == 0) check("pulse_count", hs, 7);
    @(posedge clk);
    #1;
    check("busy_after", bus.busy, 1'b0);
    check("done_one_cycle", bus.done, 1'b0);
    check("results_left", res_q.size(), 0);
    iss_q.delete();
    res_q.delete();
  endtask

  initial begin
    word_t f[6];
    word_t junk[6];
    int unsigned seen, n, pulses;
    bus.load_en = 1'b0;
    bus.start = 1'b0;
    bus.dtau_ready = 1'b1;
    for (int i = 0; i < 6; i++) f[i] = '0;
    drive_load(3'd0, '0, '0, f);
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_dtau_valid", bus.dtau_valid, 1'b0);
    check("rst_link_out", bus.link_out, 3'd0);
    check("rst_dtau_out", bus.dtau_out, '0);
    check("rst_curr_AZ", bus.curr_out_AZ, '0);
    @(negedge clk);
    reset = 1'b0;

    // Single link loaded: first result is link 7 with dtau = 3<<16.
    f = '{32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h4_0000, 32'h5_0000, 32'h6_0000};
    load_entry(7, 32'h0000_8000, 32'h0000_DDB4, f);
    do_sweep(0, 1'b0);

    // All links loaded with random vectors.
    for (int l = 1; l <= 7; l++) begin
      for (int i = 0; i < 6; i++) f[i] = $urandom;
      load_entry(l, $urandom, $urandom, f);
    end
    do_sweep(0, 1'b0);

    // Re-start on the updated accumulators with a held-off result on link 4.
    do_sweep(4, 1'b0);

    // start/load_en pulsed while busy must change nothing.
    for (int i = 0; i < 6; i++) junk[i] = 32'hDEAD_0000 + i;
    drive_load(3'd2, 32'hBAD0_0001, 32'hBAD0_0002, junk);
    do_sweep(0, 1'b1);
    for (int i = 0; i < 6; i++) f[i] = '0;
    drive_load(3'd0, '0, '0, f);
    do_sweep(0, 1'b0);

    // Reset in CAPTURE of link 4 aborts the sweep and clears storage.
    model_sweep();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    seen = 0; n = 0;
    while (seen < 2 && n < 100) begin
      if (bus.link_out == 3'd4) seen++;
      if (seen < 2) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("reach_capture4", seen, 2);
    reset = 1'b1;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_dtau_valid", bus.dtau_valid, 1'b0);
    check("abort_link_out", bus.link_out, 3'd0);
    check("abort_sinq", bus.sinq_out, '0);
    check("abort_curr_AX", bus.curr_out_AX, '0);
    check("abort_prev_LZ", bus.prev_out_LZ, '0);
    iss_q.delete();
    res_q.delete();
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.dtau_valid) pulses++;
    end
    check("abort_activity", pulses, 0);
    do_sweep(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
